// File: rtl/bn_bias_sched.sv
// Bias/BN parameter scheduler: accepts accumulator beats under downstream credit,
// fetches the per-channel parameter and tracks beats through the postproc pipe.
module bn_bias_sched #(
  parameter int unsigned CH_NUM    = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ACC_WIDTH = 40,
  parameter int unsigned BIAS_DW   = 16,
  parameter int unsigned PP_LAT    = 2,
  parameter int unsigned CREDITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          pix_num,
  output logic                 busy,
  output logic                 done,
  input  logic                 acc_valid,
  output logic                 acc_ready,
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic                 param_rd,
  output logic [ADDR_W-1:0]    param_addr,
  input  logic [BIAS_DW-1:0]   param_data,
  output logic [ACC_WIDTH-1:0] pp_acc,
  output logic [BIAS_DW-1:0]   pp_bias,
  output logic                 dout_valid,
  output logic [ADDR_W-1:0]    dout_ch,
  input  logic                 credit_ret
);

  localparam int unsigned CRED_W = $clog2(CREDITS + 1);
  localparam logic [ADDR_W-1:0] CH_LAST = ADDR_W'(CH_NUM - 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [PP_LAT-1:0] OUT_BIT = PP_LAT'(1) << (PP_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                          state, state_nxt;
  logic [15:0]                     pix_num_q;
  logic [15:0]                     pix_cnt;
  logic [ADDR_W-1:0]               ch_cnt;
  logic [CRED_W-1:0]               cred;
  logic                            accept;
  logic                            last_beat;
  logic                            in_flight;
  logic                            pp_vld;
  logic [ADDR_W-1:0]               pp_ch;
  logic [ACC_WIDTH-1:0]            acc_q;
  logic [BIAS_DW-1:0]              bias_q;
  logic [PP_LAT-1:0]               vld_sr;
  logic [PP_LAT-1:0][ADDR_W-1:0]   ch_sr;

  assign acc_ready  = (state == RUN) && (cred != '0);
  assign accept     = acc_valid && acc_ready;
  assign param_rd   = accept;
  assign param_addr = ch_cnt;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign last_beat  = accept && (ch_cnt == CH_LAST) && (pix_cnt == pix_num_q - 16'd1);
  // Beats still in the pipe after this edge; the output stage leaves now.
  assign in_flight  = pp_vld || ((vld_sr & ~OUT_BIT) != '0);

  assign pp_acc     = acc_q;
  assign pp_bias    = pp_vld ? param_data : bias_q;
  assign dout_valid = vld_sr[PP_LAT-1];
  assign dout_ch    = ch_sr[PP_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (pix_num != 16'd0) ? RUN : DONE;
      RUN:     if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (!in_flight) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Channel/pixel position within the pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_num_q <= '0;
      pix_cnt   <= '0;
      ch_cnt    <= '0;
    end else if (state == IDLE && start) begin
      pix_num_q <= pix_num;
      pix_cnt   <= '0;
      ch_cnt    <= '0;
    end else if (accept) begin
      if (ch_cnt == CH_LAST) begin
        ch_cnt  <= '0;
        pix_cnt <= pix_cnt + 16'd1;
      end else begin
        ch_cnt  <= ch_cnt + ADDR_W'(1);
      end
    end
  end

  // Downstream slot accounting; a return while full is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cred <= CRED_MAX;
    end else begin
      unique case ({accept, credit_ret})
        2'b10:   cred <= cred - CRED_W'(1);
        2'b01:   if (cred != CRED_MAX) cred <= cred + CRED_W'(1);
        default: cred <= cred;
      endcase
    end
  end

  // Postproc input stage; bias arrives from memory one cycle after the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_vld <= 1'b0;
      pp_ch  <= '0;
      acc_q  <= '0;
      bias_q <= '0;
    end else begin
      pp_vld <= accept;
      if (accept) begin
        acc_q <= acc_in;
        pp_ch <= ch_cnt;
      end
      if (pp_vld) bias_q <= param_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      ch_sr  <= '0;
    end else begin
      vld_sr[0] <= pp_vld;
      ch_sr[0]  <= pp_ch;
      for (int i = 1; i < int'(PP_LAT); i++) begin
        vld_sr[i] <= vld_sr[i-1];
        ch_sr[i]  <= ch_sr[i-1];
      end
    end
  end

endmodule

// File: tb/tb_bn_bias_sched.sv
// Bench for bn_bias_sched: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model (credit integer, beat count, output queue).
module tb_bn_bias_sched;

  localparam int unsigned CH_NUM    = 4;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned ACC_WIDTH = 40;
  localparam int unsigned BIAS_DW   = 16;
  localparam int unsigned PP_LAT    = 2;
  localparam int unsigned CREDITS   = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [15:0]          pix_num = '0;
  logic                 busy, done;
  logic                 acc_valid = 1'b0;
  logic                 acc_ready;
  logic [ACC_WIDTH-1:0] acc_in = '0;
  logic                 param_rd;
  logic [ADDR_W-1:0]    param_addr;
  logic [BIAS_DW-1:0]   param_data = '0;
  logic [ACC_WIDTH-1:0] pp_acc;
  logic [BIAS_DW-1:0]   pp_bias;
  logic                 dout_valid;
  logic [ADDR_W-1:0]    dout_ch;
  logic                 credit_ret = 1'b0;

  bn_bias_sched #(
    .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .ACC_WIDTH(ACC_WIDTH),
    .BIAS_DW(BIAS_DW), .PP_LAT(PP_LAT), .CREDITS(CREDITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_num(pix_num), .busy(busy), .done(done),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_in(acc_in),
    .param_rd(param_rd), .param_addr(param_addr), .param_data(param_data),
    .pp_acc(pp_acc), .pp_bias(pp_bias), .dout_valid(dout_valid), .dout_ch(dout_ch),
    .credit_ret(credit_ret)
  );

  always #5 clk = ~clk;

  // Parameter memory with one-cycle read latency.
  logic [BIAS_DW-1:0] pmem [CH_NUM];
  always @(posedge clk) if (param_rd) param_data <= pmem[param_addr];

  typedef struct { int t; int ch; } ev_t;

  int  n_chk = 0, n_pass = 0, n_fail = 0;
  bit  chk_en = 0;
  int  cyc = 0;
  // Reference model state
  bit  m_pass, m_active;
  int  m_total, m_count, m_cred, m_done_cyc;
  logic [ACC_WIDTH-1:0] m_acc;
  logic [BIAS_DW-1:0]   m_bias;
  ev_t m_q[$];
  // Observations
  int  n_acc, n_dv, first_acc_cyc, last_acc_cyc, first_dv_cyc, last_dv_cyc, done_obs_cyc;
  int  first_addr;
  bit  seen_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_WIDTH-1:0] rnd_acc();
    return ACC_WIDTH'({$urandom, $urandom});
  endfunction

  task automatic reset_model();
    m_pass = 0; m_active = 0; m_total = 0; m_count = 0;
    m_cred = CREDITS; m_done_cyc = -1; m_acc = '0; m_bias = '0;
    m_q.delete();
  endtask

  task automatic clear_obs();
    n_acc = 0; n_dv = 0; first_acc_cyc = -1; last_acc_cyc = -1;
    first_dv_cyc = -1; last_dv_cyc = -1; done_obs_cyc = -1; first_addr = -1;
    seen_done = 0;
  endtask

  task automatic model_check();
    bit exp_rdy, exp_dv;
    exp_rdy = m_active && (m_cred > 0);
    exp_dv  = (m_q.size() > 0) && (m_q[0].t == cyc);
    chk("busy", 64'(busy), 64'(m_pass));
    chk("done", 64'(done), 64'(m_pass && (cyc == m_done_cyc)));
    chk("acc_ready", 64'(acc_ready), 64'(exp_rdy));
    chk("param_rd", 64'(param_rd), 64'(exp_rdy && acc_valid));
    chk("param_addr", 64'(param_addr), 64'(m_count % int'(CH_NUM)));
    chk("pp_acc", 64'(pp_acc), 64'(m_acc));
    chk("pp_bias", 64'(pp_bias), 64'(m_bias));
    chk("dout_valid", 64'(dout_valid), 64'(exp_dv));
    if (exp_dv) chk("dout_ch", 64'(dout_ch), 64'(m_q[0].ch));
  endtask

  task automatic model_update();
    bit acc, was_pass;
    int ch;
    if (rst) begin
      reset_model();
    end else begin
      acc = m_active && (m_cred > 0) && acc_valid;
      was_pass = m_pass;
      if (acc) begin
        ch = m_count % int'(CH_NUM);
        m_q.push_back('{t: cyc + 1 + int'(PP_LAT), ch: ch});
        m_acc  = acc_in;
        m_bias = pmem[ch];
        m_count++;
        if (m_count == m_total) begin
          m_active = 0;
          m_done_cyc = cyc + 2 + int'(PP_LAT);
        end
      end
      if (acc && !credit_ret) m_cred--;
      else if (!acc && credit_ret && m_cred < int'(CREDITS)) m_cred++;
      if (was_pass && cyc == m_done_cyc) m_pass = 0;
      if (start && !was_pass) begin
        m_pass = 1; m_count = 0;
        m_total = int'(pix_num) * int'(CH_NUM);
        if (m_total == 0) m_done_cyc = cyc + 1;
        else begin m_active = 1; m_done_cyc = -1; end
      end
    end
    while (m_q.size() > 0 && m_q[0].t <= cyc) void'(m_q.pop_front());
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) model_check();
    if (param_rd === 1'b1) begin
      if (first_acc_cyc < 0) begin first_acc_cyc = cyc; first_addr = int'(param_addr); end
      last_acc_cyc = cyc; n_acc++;
    end
    if (dout_valid === 1'b1) begin
      if (first_dv_cyc < 0) first_dv_cyc = cyc;
      last_dv_cyc = cyc; n_dv++;
    end
    if (done === 1'b1) begin seen_done = 1; done_obs_cyc = cyc; end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_rdy"}, 64'(acc_ready), 64'(0));
    chk({tag, "_rd"}, 64'(param_rd), 64'(0));
    chk({tag, "_dv"}, 64'(dout_valid), 64'(0));
    chk({tag, "_addr"}, 64'(param_addr), 64'(0));
    chk({tag, "_ch"}, 64'(dout_ch), 64'(0));
    chk({tag, "_acc"}, 64'(pp_acc), 64'(0));
    chk({tag, "_bias"}, 64'(pp_bias), 64'(0));
  endtask

  task automatic run_to_done(input int budget);
    for (int i = 0; i < budget && !seen_done; i++) begin
      acc_in = rnd_acc();
      step();
    end
    chk("done_reached", 64'(seen_done), 64'(1));
  endtask

  initial begin
    int start_cyc;
    for (int i = 0; i < int'(CH_NUM); i++) pmem[i] = BIAS_DW'($urandom);
    reset_model();
    clear_obs();

    // Reset
    step();
    chk_en = 1;
    step();
    zero_check("rst");
    rst = 0;
    step();

    // Full pass, continuous traffic
    clear_obs();
    start = 1; pix_num = 16'd2; credit_ret = 1; step();
    start = 0; acc_valid = 1;
    run_to_done(40);
    chk("s1_beats", 64'(n_acc), 64'(8));
    chk("s1_span", 64'(last_acc_cyc - first_acc_cyc), 64'(7));
    chk("s1_dout", 64'(n_dv), 64'(8));
    chk("s1_dout_lat", 64'(first_dv_cyc - first_acc_cyc), 64'(3));
    chk("s1_done_lat", 64'(done_obs_cyc - last_dv_cyc), 64'(1));
    acc_valid = 0; step();

    // Credit exhaustion
    credit_ret = 0;
    start = 1; pix_num = 16'd2; step();
    start = 0; acc_valid = 1; clear_obs();
    for (int i = 0; i < 8; i++) begin acc_in = rnd_acc(); step(); end
    chk("s2_two_beats", 64'(n_acc), 64'(2));
    chk("s2_stalled", 64'(acc_ready), 64'(0));
    credit_ret = 1; step();
    credit_ret = 0;
    for (int i = 0; i < 5; i++) begin acc_in = rnd_acc(); step(); end
    chk("s2_one_more", 64'(n_acc), 64'(3));

    // Accept and return together at one credit
    acc_valid = 0; credit_ret = 1; step();
    acc_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("s3_ready", 64'(acc_ready), 64'(1));
      acc_in = rnd_acc();
      step();
    end
    chk("s3_beats", 64'(n_acc), 64'(8));
    run_to_done(20);
    acc_valid = 0; step();

    // Empty pass
    clear_obs();
    start = 1; pix_num = 16'd0; acc_valid = 1; start_cyc = cyc; step();
    start = 0;
    for (int i = 0; i < 5; i++) step();
    chk("s4_done_cyc", 64'(done_obs_cyc - start_cyc), 64'(1));
    chk("s4_no_rd", 64'(n_acc), 64'(0));
    chk("s4_no_dv", 64'(n_dv), 64'(0));

    // Reset mid-pass
    acc_valid = 0; step();
    start = 1; pix_num = 16'd2; credit_ret = 1; step();
    start = 0; acc_valid = 1; clear_obs();
    for (int i = 0; i < 20 && n_acc < 3; i++) begin acc_in = rnd_acc(); step(); end
    chk("s5_three", 64'(n_acc), 64'(3));
    acc_valid = 0; rst = 1; step();
    rst = 0;
    zero_check("s5");
    clear_obs();
    for (int i = 0; i < 6; i++) step();
    chk("s5_dropped", 64'(n_dv), 64'(0));
    chk("s5_no_done", 64'(seen_done), 64'(0));
    start = 1; pix_num = 16'd2; step();
    start = 0; acc_valid = 1;
    run_to_done(40);
    chk("s5_restart_addr", 64'(first_addr), 64'(0));
    chk("s5_restart_beats", 64'(n_acc), 64'(8));
    acc_valid = 0; step();

    // start during RUN is ignored
    clear_obs();
    start = 1; pix_num = 16'd2; step();
    start = 0; acc_valid = 1; pix_num = 16'd3;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      start = (i < 6) && (i % 2 == 0);
      acc_in = rnd_acc();
      step();
    end
    start = 0;
    chk("s6_done", 64'(seen_done), 64'(1));
    chk("s6_beats", 64'(n_acc), 64'(8));
    acc_valid = 0; step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(99) == 0);
      start      = ($urandom_range(19) == 0);
      pix_num    = 16'($urandom_range(3));
      acc_valid  = ($urandom_range(9) < 7);
      credit_ret = ($urandom_range(1) == 1);
      acc_in     = rnd_acc();
      step();
    end
    rst = 0; start = 0; acc_valid = 0;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
